// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pkg
// Purpose  : Shared state encodings and default constants for the HDMI path.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        TX_SETTLE  = 2'd1,
        WAIT_FRAME = 2'd2,
        RUN        = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES   = 1024;
    localparam int unsigned DEF_TX_SETTLE_CYCLES     = 16;
    localparam int unsigned DEF_FRAME_TIMEOUT_CYCLES = 4194304;
    localparam int unsigned DEF_FRAMES_PER_PATTERN   = 120;
    localparam int unsigned DEF_NUM_PATTERNS         = 4;
    localparam int unsigned DEF_SEL_W                = 2;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop single-bit synchronizer, resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff
    import hdmi_pkg::*;
(
    input  logic clk,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/hdmi_bringup_seq.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_bringup_seq
// Purpose  : PLL-lock qualification, TX/generator reset release, frame-aligned
//            video enable and pattern selection for the HDMI/DVI output path.
//            HDMI_PATTERN_AUTOCYCLE_EN selects auto-cycling patterns.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_bringup_seq
    import hdmi_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned TX_SETTLE_CYCLES     = DEF_TX_SETTLE_CYCLES,
    parameter int unsigned FRAME_TIMEOUT_CYCLES = DEF_FRAME_TIMEOUT_CYCLES,
    parameter int unsigned FRAMES_PER_PATTERN   = DEF_FRAMES_PER_PATTERN,
    parameter int unsigned NUM_PATTERNS         = DEF_NUM_PATTERNS,
    parameter int unsigned SEL_W                = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             ext_reset,
    input  logic             pll_lock,
    input  logic             vsync,
    input  logic [SEL_W-1:0] sel_in,
    output logic             tx_reset,
    output logic             gen_reset,
    output logic             video_en,
    output logic [SEL_W-1:0] pattern_sel,
    output logic [1:0]       state,
    output logic [7:0]       lock_loss_cnt
);

    localparam int unsigned c_LOCK_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned c_SETTLE_W = $clog2(TX_SETTLE_CYCLES + 1);
    localparam int unsigned c_WD_W     = $clog2(FRAME_TIMEOUT_CYCLES + 1);

    localparam logic [c_LOCK_W-1:0]   c_LOCK_END   = c_LOCK_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_END = c_SETTLE_W'(TX_SETTLE_CYCLES - 1);
    localparam logic [c_WD_W-1:0]     c_WD_END     = c_WD_W'(FRAME_TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0]      c_SEL_MAX    = SEL_W'(NUM_PATTERNS - 1);

    seq_state_e            state_q, state_d;
    logic [c_LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [c_SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [c_WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [7:0]            llc_q, llc_d;
    logic                  vsync_q;
    logic                  tx_reset_q, gen_reset_q, video_en_q;
    logic                  lock_s;
    logic                  vs_rise;

`ifdef HDMI_PATTERN_AUTOCYCLE_EN
    localparam int unsigned        c_FRAME_W   = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_END = c_FRAME_W'(FRAMES_PER_PATTERN - 1);
    logic [c_FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

    sync_2ff u_lock_sync (
        .clk    (clk),
        .rst_ni (ext_reset),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    assign vs_rise = vsync & ~vsync_q;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = '0;
        settle_cnt_d = '0;
        wd_cnt_d     = '0;
        sel_d        = sel_q;
        llc_d        = llc_q;
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
        frame_cnt_d  = frame_cnt_q;
`endif
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (lock_cnt_q == c_LOCK_END) state_d = TX_SETTLE;
                    else                          lock_cnt_d = lock_cnt_q + c_LOCK_W'(1);
                end
            end
            TX_SETTLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
                end else if (settle_cnt_q == c_SETTLE_END) begin
                    state_d = WAIT_FRAME;
                end else begin
                    settle_cnt_d = settle_cnt_q + c_SETTLE_W'(1);
                end
            end
            WAIT_FRAME, RUN: begin
                // Lock loss outranks the watchdog, which outranks vsync progress.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
                end else if (wd_cnt_q == c_WD_END) begin
                    state_d = WAIT_LOCK;
                end else if (vs_rise) begin
                    state_d = RUN;
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
                    if (state_q == RUN) begin
                        if (frame_cnt_q == c_FRAME_END) begin
                            frame_cnt_d = '0;
                            sel_d       = (sel_q == c_SEL_MAX) ? '0 : sel_q + SEL_W'(1);
                        end else begin
                            frame_cnt_d = frame_cnt_q + c_FRAME_W'(1);
                        end
                    end
`else
                    sel_d = (sel_in > c_SEL_MAX) ? c_SEL_MAX : sel_in;
`endif
                end else begin
                    wd_cnt_d = wd_cnt_q + c_WD_W'(1);
                end
            end
        endcase

        if (state_d == WAIT_LOCK) begin
            sel_d = '0;
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
            frame_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            state_q      <= WAIT_LOCK;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            wd_cnt_q     <= '0;
            sel_q        <= '0;
            llc_q        <= '0;
            vsync_q      <= 1'b0;
            tx_reset_q   <= 1'b1;
            gen_reset_q  <= 1'b1;
            video_en_q   <= 1'b0;
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            sel_q        <= sel_d;
            llc_q        <= llc_d;
            vsync_q      <= vsync;
            tx_reset_q   <= (state_d == WAIT_LOCK);
            gen_reset_q  <= (state_d == WAIT_LOCK) || (state_d == TX_SETTLE);
            video_en_q   <= (state_d == RUN);
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign tx_reset      = tx_reset_q;
    assign gen_reset     = gen_reset_q;
    assign video_en      = video_en_q;
    assign pattern_sel   = sel_q;
    assign state         = state_q;
    assign lock_loss_cnt = llc_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_bringup_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hdmi_bringup_seq
// Purpose  : Randomized scoreboard bench for hdmi_bringup_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_bringup_seq;

    localparam int LOCK   = 8;
    localparam int SETTLE = 4;
    localparam int TMO    = 100;
    localparam int FPP    = 2;
    localparam int NP     = 3;
    localparam int SW     = 2;

    localparam int F_STATE = 0, F_TX = 1, F_GEN = 2, F_VEN = 3, F_SEL = 4, F_LLC = 5;

    logic          clk = 1'b0;
    logic          ext_reset = 1'b0;
    logic          pll_lock = 1'b0;
    logic          vsync = 1'b0;
    logic [SW-1:0] sel_in = '0;
    logic          tx_reset, gen_reset, video_en;
    logic [SW-1:0] pattern_sel;
    logic [1:0]    state;
    logic [7:0]    lock_loss_cnt;

    always #5 clk = ~clk;

    hdmi_bringup_seq #(
        .LOCK_STABLE_CYCLES   (LOCK),
        .TX_SETTLE_CYCLES     (SETTLE),
        .FRAME_TIMEOUT_CYCLES (TMO),
        .FRAMES_PER_PATTERN   (FPP),
        .NUM_PATTERNS         (NP),
        .SEL_W                (SW)
    ) dut (
        .clk           (clk),
        .ext_reset     (ext_reset),
        .pll_lock      (pll_lock),
        .vsync         (vsync),
        .sel_in        (sel_in),
        .tx_reset      (tx_reset),
        .gen_reset     (gen_reset),
        .video_en      (video_en),
        .pattern_sel   (pattern_sel),
        .state         (state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    typedef struct {
        int cyc;
        int field;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state: expressed as frame/loss counts, not FSM internals.
    int   exp_sel = 0;
    int   exp_llc = 0;
    int   run_frames = 0;
    bit   m_run = 1'b0;
    int   last_rise = 0;
    int   wf_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fname(input int f);
        case (f)
            F_STATE: return "state";
            F_TX:    return "tx_reset";
            F_GEN:   return "gen_reset";
            F_VEN:   return "video_en";
            F_SEL:   return "pattern_sel";
            default: return "lock_loss_cnt";
        endcase
    endfunction

    function automatic int actual(input int f);
        case (f)
            F_STATE: return int'(state);
            F_TX:    return int'(tx_reset);
            F_GEN:   return int'(gen_reset);
            F_VEN:   return int'(video_en);
            F_SEL:   return int'(pattern_sel);
            default: return int'(lock_loss_cnt);
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: expectation for cycle %0d sampled late at cycle %0d",
                         fname(e.field), e.cyc, cyc);
            end else begin
                a = actual(e.field);
                if (a == e.val) n_pass++;
                else $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                              fname(e.field), cyc, a, e.val);
            end
        end
    end

    task automatic expect_at(input int c, input int f, input int v);
        exp_t e;
        int   i;
        e.cyc = c; e.field = f; e.val = v;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endtask

    task automatic expect_idle(input int c);
        expect_at(c, F_STATE, 0);
        expect_at(c, F_TX, 1);
        expect_at(c, F_GEN, 1);
        expect_at(c, F_VEN, 0);
        expect_at(c, F_SEL, 0);
        expect_at(c, F_LLC, exp_llc);
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) wait_edge();
    endtask

    task automatic model_to_wait_lock();
        m_run = 1'b0; exp_sel = 0; run_frames = 0;
    endtask

    // q is the edge on which tx_reset must fall.
    task automatic qualify(input int q);
        expect_at(q - 1, F_TX, 1);
        expect_at(q, F_TX, 0);
        expect_at(q, F_GEN, 1);
        expect_at(q + SETTLE - 1, F_GEN, 1);
        expect_at(q + SETTLE, F_GEN, 0);
        expect_at(q + SETTLE, F_STATE, 2);
        expect_at(q + SETTLE, F_VEN, 0);
        wf_start = q + SETTLE;
        wait_until(q + SETTLE);
    endtask

    task automatic raise_lock();
        wait_edge();
        pll_lock = 1'b1;
        qualify(cyc + LOCK + 2);
    endtask

    task automatic drop_lock();
        int e;
        wait_edge();
        pll_lock = 1'b0;
        e = cyc;
        expect_at(e + 2, F_TX, 0);
        expect_at(e + 2, F_LLC, exp_llc);
        exp_llc = (exp_llc < 255) ? exp_llc + 1 : 255;
        model_to_wait_lock();
        expect_idle(e + 3);
        wait_until(e + 4);
    endtask

    task automatic vsync_edge(input int gap, input int force_sel);
        int r;
        int s;
        for (int i = 0; i < gap; i++) begin
            wait_edge();
            if (i == gap / 2) sel_in = SW'($urandom_range(0, 3));
        end
        wait_edge();
        s = (force_sel >= 0) ? force_sel : int'($urandom_range(0, 3));
        vsync  = 1'b1;
        sel_in = SW'(s);
        r = cyc + 1;
        expect_at(r - 1, F_SEL, exp_sel);
`ifdef HDMI_PATTERN_AUTOCYCLE_EN
        if (m_run) begin
            run_frames++;
            exp_sel = (run_frames / FPP) % NP;
        end
`else
        exp_sel = (s > NP - 1) ? NP - 1 : s;
`endif
        m_run = 1'b1;
        last_rise = r;
        expect_at(r, F_SEL, exp_sel);
        expect_at(r, F_VEN, 1);
        expect_at(r, F_STATE, 3);
        wait_edge();
        repeat ($urandom_range(0, 2)) wait_edge();
        vsync = 1'b0;
    endtask

    task automatic watchdog_from(input int start, input int st);
        int w;
        w = start + TMO;
        expect_at(w - 1, F_STATE, st);
        expect_at(w, F_STATE, 0);
        expect_at(w, F_TX, 1);
        expect_at(w, F_VEN, 0);
        expect_at(w, F_SEL, 0);
        expect_at(w, F_LLC, exp_llc);
        model_to_wait_lock();
        qualify(w + LOCK);
    endtask

    initial begin
        int h;
        int lim;
        int q;
        repeat (3) wait_edge();
        expect_idle(cyc);
        wait_edge();
        ext_reset = 1'b1;
        repeat (2) wait_edge();
        expect_idle(cyc);

        // Bring-up, then a run of frames with random selects (one forced out of range).
        raise_lock();
        vsync_edge($urandom_range(1, 30), -1);
        for (int k = 0; k < 7; k++) vsync_edge($urandom_range(1, 50), (k == 2) ? 3 : -1);

        drop_lock();

        // Short lock glitch must restart qualification.
        wait_edge();
        pll_lock = 1'b1;
        h = $urandom_range(1, LOCK - 1);
        repeat (h) wait_edge();
        pll_lock = 1'b0;
        wait_edge();
        pll_lock = 1'b1;
        q = cyc + LOCK + 2;
        expect_at(q, F_LLC, exp_llc);
        qualify(q);
        vsync_edge($urandom_range(1, 30), -1);
        for (int k = 0; k < 3; k++) vsync_edge($urandom_range(1, 50), -1);

        // Watchdog from RUN, then from WAIT_FRAME, with lock held throughout.
        watchdog_from(last_rise, 3);
        watchdog_from(wf_start, 2);
        vsync_edge($urandom_range(1, 30), -1);
        for (int k = 0; k < 2; k++) vsync_edge($urandom_range(1, 50), -1);

        // Asynchronous reset mid-frame clears everything, including the loss count.
        wait_edge();
        #2;
        ext_reset = 1'b0;
        exp_llc = 0;
        model_to_wait_lock();
        expect_idle(cyc);
        repeat (2) wait_edge();
        ext_reset = 1'b1;
        qualify(cyc + LOCK + 2);
        vsync_edge($urandom_range(1, 30), -1);
        vsync_edge($urandom_range(1, 50), -1);
        drop_lock();

        // Repeated losses saturate the counter.
        for (int k = 0; k < 256; k++) begin
            wait_edge();
            pll_lock = 1'b1;
            q = cyc + LOCK + 2;
            expect_at(q, F_TX, 0);
            wait_until(q + int'($urandom_range(0, 3)));
            drop_lock();
        end
        expect_at(cyc + 1, F_LLC, 255);

        lim = cyc + 300;
        while (exp_q.size() > 0 && cyc < lim) wait_edge();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never sampled", fname(e.field), e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hdmi_bringup_seq.md
# hdmi_bringup_seq

- Power-up and recovery sequencer for the HDMI/DVI output path.
- Qualifies PLL lock, releases the TMDS transmitter reset, then the pattern-generator reset.
- Enables video only on a frame boundary and re-sequences on PLL lock loss or a stalled generator.
- Selects the active test pattern; sits between the PLL/reset logic and the `dvi_tx_top` / `test_pattern_gen` instances at top level.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before leaving WAIT_LOCK (≥2).
- `TX_SETTLE_CYCLES`, 16: cycles TX runs out of reset before generator release (≥1).
- `FRAME_TIMEOUT_CYCLES`, 4194304: maximum cycles between vsync rising edges in WAIT_FRAME/RUN.
- `FRAMES_PER_PATTERN`, 120: frames per pattern in auto-cycle mode (≥1).
- `NUM_PATTERNS`, 4: number of patterns (2..2^SEL_W).
- `SEL_W`, 2: pattern select width.

Ports:
- `clk` in 1: pixel clock; all logic on rising edge.
- `ext_reset` in 1: reset, asynchronous, active-low.
- `pll_lock` in 1: raw PLL lock, asynchronous to `clk`.
- `vsync` in 1: active-high vsync from the pattern generator, `clk` domain.
- `sel_in` in SEL_W: manual pattern select, used only without the macro.
- `tx_reset` out 1: active-high reset to the TMDS transmitter.
- `gen_reset` out 1: active-high reset to the pattern generator.
- `video_en` out 1: high only in RUN.
- `pattern_sel` out SEL_W: active pattern index.
- `state` out 2: WAIT_LOCK=0, TX_SETTLE=1, WAIT_FRAME=2, RUN=3.
- `lock_loss_cnt` out 8: saturating count of lock losses after the first qualification.

## Operation
- `pll_lock` passes through a 2-FF synchronizer; the result is `lock_s`.
- WAIT_LOCK: lock counter increments while `lock_s`=1 and clears when `lock_s`=0. Counter reaching `LOCK_STABLE_CYCLES` moves to TX_SETTLE and clears the counter.
- TX_SETTLE: settle counter runs `TX_SETTLE_CYCLES`, then moves to WAIT_FRAME.
- WAIT_FRAME: waits for a vsync rising edge (vsync=1, previous=0), then moves to RUN.
- RUN: stays in RUN until a fault.
- Lock loss (`lock_s`=0 in TX_SETTLE/WAIT_FRAME/RUN): next state WAIT_LOCK; `lock_loss_cnt` +1, saturates at 255.
- Watchdog: counts in WAIT_FRAME/RUN and clears on each vsync rising edge. Reaching `FRAME_TIMEOUT_CYCLES` sends the block to WAIT_LOCK; this is not counted as a lock loss.
- Lock loss takes priority over watchdog, and both over vsync progression, on the same cycle.
- Registered outputs, decoded from the next state:
  - `tx_reset`=1 only in WAIT_LOCK.
  - `gen_reset`=1 in WAIT_LOCK and TX_SETTLE.
  - `video_en`=1 only in RUN.
- Entering WAIT_LOCK clears `pattern_sel`, the frame counter and all timers.
- Reset values: state=WAIT_LOCK, `tx_reset`=1, `gen_reset`=1, `video_en`=0, `pattern_sel`=0, `lock_loss_cnt`=0, all counters 0.
- Assertion of `ext_reset` mid-operation forces these values immediately (asynchronous). `lock_loss_cnt` is also cleared.

## Timing
- `lock_s` follows `pll_lock` 2 edges later.
- `tx_reset` falls `LOCK_STABLE_CYCLES`+2 edges after `pll_lock` rises (steady lock).
- `gen_reset` falls `TX_SETTLE_CYCLES` edges after `tx_reset` falls.
- `video_en` rises on the edge that samples the first vsync rising edge in WAIT_FRAME.
- Lock loss: `tx_reset`=1, `gen_reset`=1, `video_en`=0 on edge 3 after `pll_lock` falls.
- `pattern_sel` changes only on an edge that samples a vsync rising edge, never mid-frame.

## Configuration
- Macro: `HDMI_PATTERN_AUTOCYCLE_EN`.
- Defined: in RUN, a frame counter increments on each vsync rising edge. On the edge where it would reach `FRAMES_PER_PATTERN`, it wraps to 0 and `pattern_sel` increments modulo `NUM_PATTERNS`. `sel_in` is ignored.
- Undefined: no frame counter. In WAIT_FRAME/RUN, `pattern_sel` loads `sel_in` on each vsync rising edge; values ≥`NUM_PATTERNS` clamp to `NUM_PATTERNS`-1.

## Structure
- Shared package `hdmi_pkg`: state enum/encodings, default parameter constants.
- One sub-module `sync_2ff` (generic 2-FF bit synchronizer, reset to 0), also reused elsewhere.
- FSM, counters and pattern logic stay in `hdmi_bringup_seq`.

## Test plan
Shared bench parameters: LOCK_STABLE_CYCLES=8, TX_SETTLE_CYCLES=4.

- Bring-up: `pll_lock` rises at edge 0 -> `tx_reset` falls at edge 10, `gen_reset` at edge 14. Vsync pulse at edge 30 -> `video_en`=1 at edge 30, state=3.
- Glitchy lock: `pll_lock` high 5 cycles, low 1, then steady -> lock counter restarts; `tx_reset` falls 10 edges after the final rise; `lock_loss_cnt`=0.
- Lock loss in RUN: drop `pll_lock` -> 3rd edge `tx_reset`=1, `gen_reset`=1, `video_en`=0, `pattern_sel`=0, `lock_loss_cnt`=1. 256 repeated losses -> count holds 255.
- Watchdog: FRAME_TIMEOUT_CYCLES=100, no vsync after `gen_reset` release -> state=0 after 100 cycles; `lock_loss_cnt` unchanged.
- Auto-cycle (macro on): FRAMES_PER_PATTERN=2, NUM_PATTERNS=3 -> `pattern_sel` 0,0,1,1,2,2,0 across 7 vsync edges in RUN.
- Manual (macro off): `sel_in`=3 with NUM_PATTERNS=3 -> `pattern_sel`=2 after next vsync edge. `sel_in` changed mid-frame -> no change until the following vsync edge.
